avalon_sram_responder: RTL
==========================

// Module: avalon_sram_responder
// PURPOSE
//  Avalon-MM slave end of avalon_interface: answers the core's Avalon master port from a local word-addressed SRAM.
//  Serves as on-chip peripheral RAM and as the bus-side model in core-level benches.
//  Fixed, configurable wait states and response latency; responses strictly in order.
// PARAMETERS
//  MEM_WORDS      1024          SRAM depth in 32-bit words; power of two
//  BASE_ADDR      32'h8000_0000 byte address of word 0; aligned to MEM_WORDS*4
//  WAIT_STATES    1             cycles waitrequest held high per command before acceptance (0..15)
//  RESP_LATENCY   2             cycles from acceptance to readdatavalid/writeresponsevalid (1..8)
// PORTS
//  clk                 in   1   clock
//  rst_n               in   1   synchronous reset, active low
//  bus.addr            in   32  byte address; bits [1:0] ignored
//  bus.read            in   1   read request
//  bus.write           in   1   write request
//  bus.byteenable      in   4   write byte lanes
//  bus.writedata       in   32  write data
//  bus.readdata        out  32  read data, valid with readdatavalid
//  bus.waitrequest     out  1   command not accepted this cycle
//  bus.readdatavalid   out  1   one-cycle pulse per accepted read
//  bus.writeresponsevalid out 1 one-cycle pulse per accepted write
//  err_count           out  16  out-of-range command count (see CONFIGURATION)
//  (bus is avalon_interface.slave.)
// BEHAVIOUR
//  Reset (rst_n low at a clock edge): waitrequest=1, readdatavalid=0, writeresponsevalid=0, readdata=0, err_count=0,
//   FSM->IDLE, response pipe flushed (in-flight responses dropped). SRAM contents not cleared.
//  Accept: a command (read|write) is accepted in the cycle where it is asserted and waitrequest=0; one accept per cycle max.
//  Wait-state FSM: IDLE -> WAIT on request with WAIT_STATES>0; wcnt counts 1..WAIT_STATES; waitrequest=1 in IDLE-with-request
//   and while wcnt<WAIT_STATES; at wcnt==WAIT_STATES waitrequest=0, command accepted, -> IDLE. Next command restarts the count.
//   WAIT_STATES=0: waitrequest=0 combinationally whenever out of reset; back-to-back accepts every cycle.
//   Request dropped during WAIT (protocol violation): -> IDLE, no access, no response.
//  addr/writedata/byteenable sampled only in the accept cycle.
//  read && write together: treated as read; write ignored; sim-only assertion fires.
//  Write: only lanes with byteenable[i]=1 update; byteenable=0 still produces a response.
//  Response pipe: RESP_LATENCY-deep shift register of {valid, is_write, data}; SRAM read registered in stage 1.
//   Accept at cycle N -> response pulse at cycle N+RESP_LATENCY; readdata held from last read between pulses.
//   Never stalls (Avalon master has no response backpressure); at most one response per cycle, order = accept order.
//  Read-after-write same word, back-to-back accepts: read returns newly written data (write-first).
//  Word index = (addr - BASE_ADDR) >> 2; subtraction is 32-bit wrap-around.
// CONFIGURATION
//  AVALON_RESPONDER_BOUNDS_EN defined: index >= MEM_WORDS is out of range; such reads return 32'hBADA_DD00,
//   writes discarded, both still respond with normal latency; err_count += 1 per such accept, saturates at 16'hFFFF.
//  Not defined: index taken modulo MEM_WORDS (aliasing), err_count tied to 0.
// STRUCTURE
//  Package avalon_responder_pkg: resp_entry_t {valid, is_write, data[31:0]}, BAD_ADDR_DATA constant, wait-FSM state enum.
//  Sub-module avalon_resp_pipe: parameterised RESP_LATENCY shift register of resp_entry_t with synchronous flush.
//  SRAM inferred as byte-lane-write block RAM in the top module.
// TESTING
//  WAIT_STATES=1, RESP_LATENCY=2: write 0x8000_0010 <= 32'hCAFE_F00D, be=4'hF -> waitrequest high 1 cycle, writeresponsevalid 2 cycles after accept.
//  Read 0x8000_0010 after above -> readdatavalid at accept+2, readdata=32'hCAFE_F00D.
//  Write be=4'b0010 data 32'h0000_AB00 to same word, read -> 32'hCAFE_ABOD with byte1=8'hAB, i.e. 32'hCAFE_AB0D.
//  WAIT_STATES=0: 4 back-to-back reads of words 0..3 -> 4 consecutive readdatavalid pulses, data in order.
//  BOUNDS_EN, MEM_WORDS=1024: read 0x8000_1000 -> readdata=32'hBADA_DD00, err_count=1; write same addr -> no SRAM change, err_count=2.
//  rst_n low 1 cycle with 2 reads in flight -> no readdatavalid afterwards, waitrequest=1 during reset, err_count=0.

Source files
------------

// File: rtl/avalon_responder_pkg.sv
// Shared types for the Avalon-MM SRAM responder: response pipe entry, wait-state FSM encoding,
// and the read data returned for out-of-range accesses.
package avalon_responder_pkg;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [31:0] data;
   } resp_entry_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } wait_state_t;

   localparam logic [31:0] BAD_ADDR_DATA = 32'hBADA_DD00;

   localparam resp_entry_t RESP_NONE = '{valid: 1'b0, is_write: 1'b0, data: 32'h0};

endpackage

// File: rtl/avalon_interface.sv
// Avalon-MM signal bundle between the core's master port and a memory-mapped slave.
interface avalon_interface;

   logic [31:0] addr;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        waitrequest;
   logic        readdatavalid;
   logic        writeresponsevalid;

   modport slave (
      input  addr, read, write, byteenable, writedata,
      output readdata, waitrequest, readdatavalid, writeresponsevalid
   );

   modport master (
      output addr, read, write, byteenable, writedata,
      input  readdata, waitrequest, readdatavalid, writeresponsevalid
   );

endinterface

// File: rtl/avalon_resp_pipe.sv
// Fixed-latency response shift register that follows the SRAM read register; flush empties every stage.
// DEPTH = 0 is a straight pass-through for a response latency of one cycle.
module avalon_resp_pipe
   import avalon_responder_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic        clk,
   input  logic        flush,
   input  resp_entry_t in_entry,
   output resp_entry_t out_entry
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign out_entry = in_entry;
      end else begin : g_shift
         resp_entry_t stage_q [DEPTH];

         always_ff @(posedge clk) begin
            if (flush) begin
               for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESP_NONE;
            end else begin
               stage_q[0] <= in_entry;
               for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
         end

         assign out_entry = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/avalon_sram_responder.sv
// Avalon-MM slave answering from a local word-addressed SRAM with fixed wait states and response latency.
// Build option AVALON_RESPONDER_BOUNDS_EN: reject indices >= MEM_WORDS and count them in err_count.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no command being held off; a request here raises waitrequest
// ST_WAIT | counting wait states in wcnt; accept when wcnt == WAIT_STATES
module avalon_sram_responder
   import avalon_responder_pkg::*;
#(
   parameter int          MEM_WORDS    = 1024,
   parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
   parameter int          WAIT_STATES  = 1,
   parameter int          RESP_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   avalon_interface.slave        bus,
   output logic [15:0]           err_count
);

   localparam int         AW = $clog2(MEM_WORDS);
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   wait_state_t state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic        req, accept, acc_read, acc_write;

   assign req = bus.read | bus.write;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req && (WAIT_STATES != 0)) begin
               state_d = ST_WAIT;
               wcnt_d  = 4'd1;
            end
         end
         ST_WAIT: begin
            // a request withdrawn mid-wait is abandoned without an access
            if (!req || (wcnt_q == WS)) begin
               state_d = ST_IDLE;
               wcnt_d  = '0;
            end else begin
               wcnt_d  = wcnt_q + 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            wcnt_d  = '0;
         end
      endcase
   end

   always_comb begin
      bus.waitrequest = 1'b1;
      if (!rst_n)
         bus.waitrequest = 1'b1;
      else if (WAIT_STATES == 0)
         bus.waitrequest = 1'b0;
      else if ((state_q == ST_WAIT) && (wcnt_q == WS))
         bus.waitrequest = 1'b0;
   end

   assign accept    = req & ~bus.waitrequest;
   assign acc_read  = accept & bus.read;
   assign acc_write = accept & bus.write & ~bus.read;

   logic [31:0]   offset;
   logic [29:0]   word_full;
   logic [AW-1:0] idx;
   logic          oob;
   logic          unused_bits;

   assign offset      = bus.addr - BASE_ADDR;
   assign word_full   = offset[31:2];
   assign idx         = word_full[AW-1:0];
   assign unused_bits = ^{offset[1:0], word_full};

`ifdef AVALON_RESPONDER_BOUNDS_EN
   assign oob = (word_full >= 30'(MEM_WORDS));
`else
   assign oob = 1'b0;
`endif

   logic [31:0] mem [MEM_WORDS];
   logic [31:0] rd_q;

   always_ff @(posedge clk) begin
      if (acc_write && !oob) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.byteenable[b]) mem[idx][8*b +: 8] <= bus.writedata[8*b +: 8];
         end
      end
   end

   // Write lands one edge before any following read, so back-to-back RAW is write-first.
   always_ff @(posedge clk) begin
      if (acc_read) rd_q <= mem[idx];
   end

   logic        s1_valid_q, s1_write_q, s1_bad_q;
   resp_entry_t s1_entry, out_entry;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_write_q <= 1'b0;
         s1_bad_q   <= 1'b0;
      end else begin
         s1_valid_q <= accept;
         s1_write_q <= acc_write;
         s1_bad_q   <= oob;
      end
   end

   assign s1_entry = '{valid: s1_valid_q, is_write: s1_write_q,
                       data: s1_bad_q ? BAD_ADDR_DATA : rd_q};

   avalon_resp_pipe #(.DEPTH(RESP_LATENCY - 1)) u_resp_pipe (
      .clk       (clk),
      .flush     (!rst_n),
      .in_entry  (s1_entry),
      .out_entry (out_entry)
   );

   logic        rd_pulse;
   logic [31:0] rdata_hold_q;

   assign rd_pulse = out_entry.valid & ~out_entry.is_write;

   always_ff @(posedge clk) begin
      if (!rst_n)        rdata_hold_q <= '0;
      else if (rd_pulse) rdata_hold_q <= out_entry.data;
   end

   assign bus.readdata           = rd_pulse ? out_entry.data : rdata_hold_q;
   assign bus.readdatavalid      = rd_pulse;
   assign bus.writeresponsevalid = out_entry.valid & out_entry.is_write;

`ifdef AVALON_RESPONDER_BOUNDS_EN
   logic [15:0] err_q;

   always_ff @(posedge clk) begin
      if (!rst_n)                                   err_q <= '0;
      else if (accept && oob && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
   end

   assign err_count = err_q;
`else
   assign err_count = '0;
`endif

`ifndef SYNTHESIS
   a_read_write_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(bus.read && bus.write));
`endif

endmodule
